// File: rtl/circular_fifo.sv
// Circular-buffer FIFO with occupancy count, programmable thresholds,
// registered read data and overflow/underflow pulses.
module circular_fifo #(
    parameter int WIDTH    = 8,
    parameter int DEPTH    = 8,
    parameter int AF_LEVEL = DEPTH - 1,
    parameter int AE_LEVEL = 1
) (
    input  logic                       clock,
    input  logic                       reset,
    input  logic                       enqueue,
    input  logic [WIDTH-1:0]           q_in,
    input  logic                       dequeue,
    output logic [WIDTH-1:0]           q_out,
    output logic                       q_valid,
    output logic [$clog2(DEPTH+1)-1:0] count,
    output logic                       full,
    output logic                       empty,
    output logic                       almost_full,
    output logic                       almost_empty,
    output logic                       overflow,
    output logic                       underflow
);

    localparam int PW = $clog2(DEPTH);
    localparam int CW = $clog2(DEPTH + 1);

    logic [WIDTH-1:0] mem [DEPTH];
    logic [PW-1:0]    wr_ptr;
    logic [PW-1:0]    rd_ptr;
    logic [PW-1:0]    wr_ptr_nxt;
    logic [PW-1:0]    rd_ptr_nxt;
    logic [CW-1:0]    cnt;
    logic             enq_ok;
    logic             deq_ok;

    // Flags come only from the registered count.
    assign count        = cnt;
    assign full         = (cnt == CW'(DEPTH));
    assign empty        = (cnt == '0);
    assign almost_full  = (cnt >= CW'(AF_LEVEL));
    assign almost_empty = (cnt <= CW'(AE_LEVEL));

    // A full FIFO still takes a write when a read frees a slot this cycle.
    assign deq_ok = dequeue && !empty;
    assign enq_ok = enqueue && (!full || deq_ok);

    // Non-power-of-two depths need an explicit wrap compare.
    assign wr_ptr_nxt = (wr_ptr == PW'(DEPTH - 1)) ? '0 : wr_ptr + PW'(1);
    assign rd_ptr_nxt = (rd_ptr == PW'(DEPTH - 1)) ? '0 : rd_ptr + PW'(1);

    always_ff @(posedge clock) begin
        if (!reset && enq_ok) begin
            mem[wr_ptr] <= q_in;
        end
    end

    always_ff @(posedge clock) begin
        if (reset) begin
            wr_ptr <= '0;
            rd_ptr <= '0;
        end else begin
            if (enq_ok) begin
                wr_ptr <= wr_ptr_nxt;
            end
            if (deq_ok) begin
                rd_ptr <= rd_ptr_nxt;
            end
        end
    end

    always_ff @(posedge clock) begin
        if (reset) begin
            cnt <= '0;
        end else begin
            unique case ({enq_ok, deq_ok})
                2'b10:   cnt <= cnt + CW'(1);
                2'b01:   cnt <= cnt - CW'(1);
                default: cnt <= cnt;
            endcase
        end
    end

    always_ff @(posedge clock) begin
        if (reset) begin
            q_out   <= '0;
            q_valid <= 1'b0;
        end else begin
            q_valid <= deq_ok;
            if (deq_ok) begin
                q_out <= mem[rd_ptr];
            end
        end
    end

    always_ff @(posedge clock) begin
        if (reset) begin
            overflow  <= 1'b0;
            underflow <= 1'b0;
        end else begin
            overflow  <= enqueue && !enq_ok;
            underflow <= dequeue && !deq_ok;
        end
    end

endmodule
